// File: rtl/netlist_pattern_bist_ctrl.sv
// Self-test driver for a 45-input/1-output combinational netlist: LFSR patterns
// are held on the netlist inputs, the output is sampled after a settle window and folded into a CRC-16.
module netlist_pattern_bist_ctrl #(
  parameter int              IN_W        = 45,
  parameter logic [IN_W-1:0] SEED        = 45'h1,
  parameter int              SETTLE_CYC  = 2,
  parameter int              PATTERN_CNT = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [IN_W-1:0] pat_out,
  output logic            launch,
  input  logic            dut_resp,
  output logic            busy,
  output logic            done,
  output logic [15:0]     pat_idx,
  output logic [15:0]     signature,
  input  logic [15:0]     golden_sig,
  output logic            pass,
  output logic [2:0]      dbg_state
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF =
    (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] PAT_LAST    = 16'(PATTERN_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] pat_q, pat_d;
  logic [15:0]     sig_q, sig_d;
  logic [15:0]     idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] p);
    logic fb;
    fb = p[IN_W-1] ^ p[IN_W-2] ^ p[IN_W-4] ^ p[IN_W-5];
    return {p[IN_W-2:0], fb};
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic r);
    logic f;
    f = s[15] ^ r;
    return {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= SEED_EFF;
      sig_q   <= 16'hFFFF;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // start is a level sampled only in IDLE/DONE; abort wins over everything,
  // and in IDLE it only reloads values that are already there.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sig_d   = sig_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      pat_d   = SEED_EFF;
      sig_d   = 16'hFFFF;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LAUNCH;
            pat_d   = SEED_EFF;
            sig_d   = 16'hFFFF;
            idx_d   = '0;
          end
        end
        S_LAUNCH: begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
        S_SETTLE: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          sig_d = crc_step(sig_q, dut_resp);
          // The vector only moves on when another pattern follows, so DONE holds the last one.
          if (idx_q == PAT_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            pat_d   = lfsr_step(pat_q);
            state_d = S_LAUNCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pat_out   = pat_q;
  assign signature = sig_q;
  assign pat_idx   = idx_q;
  assign launch    = (state_q == S_LAUNCH);
  assign busy      = (state_q == S_LAUNCH) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (sig_q == golden_sig);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_netlist_pattern_bist_ctrl.sv
// Bench for netlist_pattern_bist_ctrl: four differently parameterised instances run in turn
// against a pattern/signature model; a negedge monitor pops expected launch and done events.
module tb_netlist_pattern_bist_ctrl;

  localparam int              NP    [4] = '{1, 4, 3, 40};
  localparam int              NS    [4] = '{2, 2, 1, 3};
  localparam logic [44:0]     SEEDS [4] = '{45'h1, 45'h1, 45'h1A2B3C4D5E6, 45'h0};

  typedef struct {
    int          inst;
    int          cyc;
    logic [44:0] pat;
    logic [15:0] idx;
    logic [15:0] sig;
  } launch_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic [15:0] sig;
    logic        pass;
    logic [15:0] idx;
  } done_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  logic [3:0]  start = '0, abort = '0, inv = '0;
  logic [3:0]  launch, busy, done, pass, dut_resp;
  logic [44:0] pat_out [4];
  logic [44:0] mask    [4] = '{default: '0};
  logic [15:0] pat_idx [4], signature [4];
  logic [15:0] golden  [4] = '{default: '0};
  logic [2:0]  dbg     [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    netlist_pattern_bist_ctrl #(
      .IN_W(45), .SEED(SEEDS[g]), .SETTLE_CYC(NS[g]), .PATTERN_CNT(NP[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
      .pat_out(pat_out[g]), .launch(launch[g]), .dut_resp(dut_resp[g]),
      .busy(busy[g]), .done(done[g]), .pat_idx(pat_idx[g]),
      .signature(signature[g]), .golden_sig(golden[g]), .pass(pass[g]),
      .dbg_state(dbg[g])
    );
  end

  // Stand-in netlist: output is the parity of masked inputs, optionally inverted.
  always_comb begin
    for (int i = 0; i < 4; i++) dut_resp[i] = (^(pat_out[i] & mask[i])) ^ inv[i];
  end

  // reference model
  function automatic logic [44:0] eff_seed(input int i);
    return (SEEDS[i] == 45'h0) ? 45'h1 : SEEDS[i];
  endfunction

  function automatic logic [44:0] lfsr(input logic [44:0] p);
    return {p[43:0], p[44] ^ p[43] ^ p[41] ^ p[40]};
  endfunction

  function automatic logic [15:0] crc(input logic [15:0] s, input logic r);
    return (s << 1) ^ (((s[15] ^ r) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  // scoreboard
  launch_t exp_l[$];
  done_t   exp_d[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, i, got, want, $time);
    end
  endtask

  logic [44:0] prev_pat [4];
  logic [15:0] prev_sig [4];
  logic [3:0]  prev_done = '0;

  always @(negedge clk) begin
    launch_t el;
    done_t   ed;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (launch[i]) begin
          if (exp_l.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_launch inst%0d: got launch at cycle %0d expected none", i, cycle);
          end else begin
            el = exp_l.pop_front();
            chk("launch_inst", i, 64'(i), 64'(el.inst));
            chk("launch_cycle", i, 64'(cycle), 64'(el.cyc));
            chk("launch_pat", i, 64'(pat_out[i]), 64'(el.pat));
            chk("launch_idx", i, 64'(pat_idx[i]), 64'(el.idx));
            chk("launch_sig", i, 64'(signature[i]), 64'(el.sig));
          end
        end
        if (done[i] && !prev_done[i]) begin
          if (exp_d.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done inst%0d: got done at cycle %0d expected none", i, cycle);
          end else begin
            ed = exp_d.pop_front();
            chk("done_inst", i, 64'(i), 64'(ed.inst));
            chk("done_cycle", i, 64'(cycle), 64'(ed.cyc));
            chk("done_sig", i, 64'(signature[i]), 64'(ed.sig));
            chk("done_pass", i, 64'(pass[i]), 64'(ed.pass));
            chk("done_idx", i, 64'(pat_idx[i]), 64'(ed.idx));
          end
        end
        if ((busy[i] && !launch[i]) || (done[i] && prev_done[i]))
          chk("pat_stable", i, 64'(pat_out[i]), 64'(prev_pat[i]));
        if (done[i] && prev_done[i])
          chk("sig_hold", i, 64'(signature[i]), 64'(prev_sig[i]));
        if (!done[i]) chk("pass_low", i, 64'(pass[i]), 64'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      prev_pat[i] = pat_out[i];
      prev_sig[i] = signature[i];
    end
    prev_done = done;
  end

  // driver tasks
  task automatic run(input int i, input logic [44:0] m, input logic iv, input bit match,
                     input logic [15:0] g_in, output int base);
    logic [44:0] p;
    logic [15:0] s;
    int          per;
    launch_t     el;
    done_t       ed;
    @(negedge clk);
    per  = 2 + NS[i];
    base = cycle + 1;
    p    = eff_seed(i);
    s    = 16'hFFFF;
    for (int k = 0; k < NP[i]; k++) begin
      el = '{i, base + k * per, p, 16'(k), s};
      exp_l.push_back(el);
      s = crc(s, (^(p & m)) ^ iv);
      p = lfsr(p);
    end
    ed = '{i, base + NP[i] * per, s, match ? 1'b1 : (s == g_in), 16'(NP[i] - 1)};
    exp_d.push_back(ed);
    mask[i]   = m;
    inv[i]    = iv;
    golden[i] = match ? s : g_in;
    start[i]  = 1'b1;
    @(negedge clk);
    start[i]  = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int limit;
    limit = NP[i] * (2 + NS[i]) + 10;
    for (int t = 0; t < limit && !done[i]; t++) @(negedge clk);
    if (!done[i]) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout inst%0d: got done=0 expected done=1 within %0d cycles", i, limit);
      exp_l.delete();
      exp_d.delete();
    end
  endtask

  task automatic wait_cycle(input int target);
    for (int t = 0; t < 200 && cycle < target; t++) @(negedge clk);
    chk("wait_cycle", 0, 64'(cycle), 64'(target));
  endtask

  task automatic chk_idle(input string name, input int i);
    chk({name, "_pat"}, i, 64'(pat_out[i]), 64'(eff_seed(i)));
    chk({name, "_sig"}, i, 64'(signature[i]), 64'hFFFF);
    chk({name, "_idx"}, i, 64'(pat_idx[i]), 64'd0);
    chk({name, "_busy"}, i, 64'(busy[i]), 64'd0);
    chk({name, "_done"}, i, 64'(done[i]), 64'd0);
    chk({name, "_pass"}, i, 64'(pass[i]), 64'd0);
    chk({name, "_launch"}, i, 64'(launch[i]), 64'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle("reset", i);
    rst_n = 1'b1;

    // abort in IDLE changes nothing
    @(negedge clk);
    abort[2] = 1'b1;
    @(negedge clk);
    abort[2] = 1'b0;
    @(negedge clk);
    chk_idle("idle_abort", 2);

    // single pattern, response 0 then 1; restart from DONE
    run(0, 45'h0, 1'b0, 1'b0, 16'hEFDF, base);
    wait_done(0);
    chk("sig_resp0", 0, 64'(signature[0]), 64'hEFDF);
    repeat (3) @(negedge clk);
    run(0, 45'h0, 1'b1, 1'b0, 16'h0000, base);
    wait_done(0);
    chk("sig_resp1", 0, 64'(signature[0]), 64'hFFFE);
    repeat (2) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk_idle("done_abort", 0);

    // random netlists on the other configurations
    run(1, 45'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), 1'b0, 16'($urandom()), base);
    wait_done(1);
    run(2, 45'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), 1'b1, 16'h0, base);
    wait_done(2);
    run(2, 45'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), 1'b0, 16'($urandom()), base);
    wait_done(2);

    // start while busy is ignored
    run(3, 45'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), 1'b1, 16'h0, base);
    repeat ($urandom_range(5, 150)) @(negedge clk);
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    wait_done(3);

    // abort together with start while capturing the second pattern
    run(1, 45'({$urandom(), $urandom()}), 1'b0, 1'b0, 16'h0, base);
    wait_cycle(base + (2 + NS[1]) + 1 + NS[1]);
    abort[1] = 1'b1;
    start[1] = 1'b1;
    exp_l.delete();
    exp_d.delete();
    @(negedge clk);
    abort[1] = 1'b0;
    start[1] = 1'b0;
    chk_idle("capture_abort", 1);

    // asynchronous reset in the middle of SETTLE
    run(2, 45'({$urandom(), $urandom()}), 1'b0, 1'b0, 16'h0, base);
    wait_cycle(base + 1);
    rst_n = 1'b0;
    #1;
    exp_l.delete();
    exp_d.delete();
    for (int i = 0; i < 4; i++) chk_idle("async_reset", i);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("launch_left", 0, 64'(exp_l.size()), 64'd0);
    chk("done_left", 0, 64'(exp_d.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
